// File: rtl/traffic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | traffic_pkg : state codes, light encodings and helpers for the       |
// |               highway/farm traffic light controller                  |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package traffic_pkg;

    typedef enum logic [2:0] {
        HGRE_FRED = 3'd0,
        HYEL_FRED = 3'd1,
        ALLRED1   = 3'd2,
        HRED_FGRE = 3'd3,
        HRED_FYEL = 3'd4,
        ALLRED2   = 3'd5,
        FLASH     = 3'd6
    } state_e;

    localparam logic [2:0] LIGHT_RED = 3'b100;
    localparam logic [2:0] LIGHT_YEL = 3'b010;
    localparam logic [2:0] LIGHT_GRN = 3'b001;
    localparam logic [2:0] LIGHT_OFF = 3'b000;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tick_gen : divides clk into a one-cycle tick every CLK_DIV cycles    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tick_gen #(
    parameter int CLK_DIV = 50000000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int             C_W    = $clog2(CLK_DIV);
    localparam logic [C_W-1:0] C_LAST = C_W'(CLK_DIV - 1);

    logic [C_W-1:0] r_cnt;

    assign tick = (r_cnt == C_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + C_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/traffic_light_ctrl_p.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | traffic_light_ctrl_p : highway/farm light FSM with request latch,    |
// |                        farm extension, all-red and flash mode        |
// | Revision             : 1.0                                           |
// +----------------------------------------------------------------------+
module traffic_light_ctrl_p
    import traffic_pkg::*;
#(
    parameter int CLK_DIV      = 50000000,
    parameter int HW_MIN_GREEN = 10,
    parameter int YELLOW_TIME  = 3,
    parameter int ALL_RED_TIME = 1,
    parameter int FARM_MIN     = 5,
    parameter int FARM_MAX     = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sensor,
    input  logic       flash_mode,
    output logic [2:0] light_highway,
    output logic [2:0] light_farm,
    output logic [2:0] state_o
);

    // Saturate at the longest duration (FARM_MAX in any sane configuration)
    // so that every exit threshold stays reachable.
    localparam int C_MAX_DUR = max_of(max_of(max_of(HW_MIN_GREEN, YELLOW_TIME),
                                             max_of(ALL_RED_TIME, FARM_MIN)), FARM_MAX);
    localparam int C_EW      = $clog2(C_MAX_DUR) + 1;
    localparam int C_EW1     = C_EW + 1;

    localparam logic [C_EW-1:0] C_SAT    = C_EW'(C_MAX_DUR);
    localparam logic [C_EW:0]   C_E_HW   = C_EW1'(HW_MIN_GREEN);
    localparam logic [C_EW:0]   C_E_YEL  = C_EW1'(YELLOW_TIME);
    localparam logic [C_EW:0]   C_E_AR   = C_EW1'(ALL_RED_TIME);
    localparam logic [C_EW:0]   C_E_FMIN = C_EW1'(FARM_MIN);
    localparam logic [C_EW:0]   C_E_FMAX = C_EW1'(FARM_MAX);

    logic            w_tick;
    logic [2:0]      r_state;
    logic [2:0]      w_next;
    logic [C_EW-1:0] r_elapsed;
    logic [C_EW:0]   w_e;
    logic            r_req;
    logic            r_flash_phase;

    tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    assign w_e = {1'b0, r_elapsed} + C_EW1'(1);

    always_comb begin
        w_next = r_state;
        if (flash_mode) begin
            w_next = FLASH;
        end else begin
            case (r_state)
                HGRE_FRED: if (w_tick && r_req && (w_e >= C_E_HW)) w_next = HYEL_FRED;
                HYEL_FRED: if (w_tick && (w_e == C_E_YEL))
                               w_next = (ALL_RED_TIME == 0) ? HRED_FGRE : ALLRED1;
                ALLRED1:   if (w_tick && (w_e == C_E_AR)) w_next = HRED_FGRE;
                HRED_FGRE: if (w_tick && (w_e >= C_E_FMIN) && (!sensor || (w_e == C_E_FMAX)))
                               w_next = HRED_FYEL;
                HRED_FYEL: if (w_tick && (w_e == C_E_YEL))
                               w_next = (ALL_RED_TIME == 0) ? HGRE_FRED : ALLRED2;
                ALLRED2:   if (w_tick && (w_e == C_E_AR)) w_next = HGRE_FRED;
                FLASH:     w_next = (ALL_RED_TIME == 0) ? HGRE_FRED : ALLRED2;
                default:   w_next = HGRE_FRED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= HGRE_FRED;
            r_elapsed     <= '0;
            r_req         <= 1'b0;
            r_flash_phase <= 1'b1;
        end else begin
            r_state <= w_next;

            if (w_next != r_state) begin
                r_elapsed <= '0;
            end else if (w_tick && (r_elapsed != C_SAT)) begin
                r_elapsed <= r_elapsed + C_EW'(1);
            end

            // Entering farm green serves the request; a coincident sensor is dropped.
            if ((w_next == HRED_FGRE) && (r_state != HRED_FGRE)) begin
                r_req <= 1'b0;
            end else if (sensor) begin
                r_req <= 1'b1;
            end

            if (r_state != FLASH) begin
                r_flash_phase <= 1'b1;
            end else if (w_tick) begin
                r_flash_phase <= ~r_flash_phase;
            end
        end
    end

    always_comb begin
        light_highway = LIGHT_RED;
        light_farm    = LIGHT_RED;
        case (r_state)
            HGRE_FRED: begin light_highway = LIGHT_GRN; light_farm = LIGHT_RED; end
            HYEL_FRED: begin light_highway = LIGHT_YEL; light_farm = LIGHT_RED; end
            ALLRED1:   begin light_highway = LIGHT_RED; light_farm = LIGHT_RED; end
            HRED_FGRE: begin light_highway = LIGHT_RED; light_farm = LIGHT_GRN; end
            HRED_FYEL: begin light_highway = LIGHT_RED; light_farm = LIGHT_YEL; end
            ALLRED2:   begin light_highway = LIGHT_RED; light_farm = LIGHT_RED; end
            FLASH: begin
                light_highway = r_flash_phase ? LIGHT_YEL : LIGHT_OFF;
                light_farm    = r_flash_phase ? LIGHT_RED : LIGHT_OFF;
            end
            default: begin light_highway = LIGHT_RED; light_farm = LIGHT_RED; end
        endcase
    end

    assign state_o = r_state;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_ctrl_p.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_traffic_light_ctrl_p : self-checking bench for the traffic FSM    |
// | Revision                : 1.0                                        |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_traffic_light_ctrl_p;
    import traffic_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       sensor;
    logic       flash_mode;
    logic [2:0] lh, lf, st;
    logic [2:0] lh0, lf0, st0;

    always #5 clk = ~clk;

    traffic_light_ctrl_p #(
        .CLK_DIV(4), .HW_MIN_GREEN(5), .YELLOW_TIME(3),
        .ALL_RED_TIME(1), .FARM_MIN(4), .FARM_MAX(10)
    ) dut (
        .clk(clk), .rst(rst), .sensor(sensor), .flash_mode(flash_mode),
        .light_highway(lh), .light_farm(lf), .state_o(st)
    );

    traffic_light_ctrl_p #(
        .CLK_DIV(4), .HW_MIN_GREEN(5), .YELLOW_TIME(3),
        .ALL_RED_TIME(0), .FARM_MIN(4), .FARM_MAX(10)
    ) dut0 (
        .clk(clk), .rst(rst), .sensor(sensor), .flash_mode(flash_mode),
        .light_highway(lh0), .light_farm(lf0), .state_o(st0)
    );

    typedef struct {
        int         tst;
        int         cyc;
        logic [2:0] st;
        logic [2:0] lh;
        logic [2:0] lf;
    } exp_t;

    typedef struct {
        int ncyc;
        int s1_lo, s1_hi, s2_lo, s2_hi, f_lo, f_hi;
    } test_t;

    int    n_cmp = 0;
    int    n_bad = 0;
    exp_t  etab[$];
    exp_t  sb[$];
    test_t ttab[5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int cyc, input logic [8:0] act, input logic [8:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic add(input int t, input int c, input logic [2:0] s, input logic [2:0] h, input logic [2:0] f);
        exp_t e;
        e.tst = t; e.cyc = c; e.st = s; e.lh = h; e.lf = f;
        etab.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1; sensor = 1'b0; flash_mode = 1'b0;
        sb.delete();
        step(); step();
        chk("reset_main", -1, {st, lh, lf},    {3'd0, LIGHT_GRN, LIGHT_RED});
        chk("reset_ar0",  -1, {st0, lh0, lf0}, {3'd0, LIGHT_GRN, LIGHT_RED});
        chk("reset_req",  -1, {8'd0, dut.r_req}, 9'd0);
        rst = 1'b0;
    endtask

    initial begin
        exp_t e;
        rst = 1'b1; sensor = 1'b0; flash_mode = 1'b0;

        // stimulus windows (-1,-1 = unused)
        ttab[0] = '{200, -1, -1,  -1, -1, -1, -1};
        ttab[1] = '{70,   2,  2,  -1, -1, -1, -1};
        ttab[2] = '{115,  0, 999, -1, -1, -1, -1};
        ttab[3] = '{78,   2,  2,  45, 45, 40, 52};
        ttab[4] = '{62,   2,  2,  -1, -1, -1, -1};

        add(0,   0, 3'd0, LIGHT_GRN, LIGHT_RED);
        add(0, 100, 3'd0, LIGHT_GRN, LIGHT_RED);
        add(0, 199, 3'd0, LIGHT_GRN, LIGHT_RED);

        add(1, 18, 3'd0, LIGHT_GRN, LIGHT_RED);
        add(1, 19, 3'd1, LIGHT_YEL, LIGHT_RED);
        add(1, 30, 3'd1, LIGHT_YEL, LIGHT_RED);
        add(1, 31, 3'd2, LIGHT_RED, LIGHT_RED);
        add(1, 34, 3'd2, LIGHT_RED, LIGHT_RED);
        add(1, 35, 3'd3, LIGHT_RED, LIGHT_GRN);
        add(1, 50, 3'd3, LIGHT_RED, LIGHT_GRN);
        add(1, 51, 3'd4, LIGHT_RED, LIGHT_YEL);
        add(1, 62, 3'd4, LIGHT_RED, LIGHT_YEL);
        add(1, 63, 3'd5, LIGHT_RED, LIGHT_RED);
        add(1, 66, 3'd5, LIGHT_RED, LIGHT_RED);
        add(1, 67, 3'd0, LIGHT_GRN, LIGHT_RED);

        add(2, 34,  3'd2, LIGHT_RED, LIGHT_RED);
        add(2, 35,  3'd3, LIGHT_RED, LIGHT_GRN);
        add(2, 74,  3'd3, LIGHT_RED, LIGHT_GRN);
        add(2, 75,  3'd4, LIGHT_RED, LIGHT_YEL);
        add(2, 87,  3'd5, LIGHT_RED, LIGHT_RED);
        add(2, 90,  3'd5, LIGHT_RED, LIGHT_RED);
        add(2, 91,  3'd0, LIGHT_GRN, LIGHT_RED);
        add(2, 110, 3'd0, LIGHT_GRN, LIGHT_RED);
        add(2, 111, 3'd1, LIGHT_YEL, LIGHT_RED);

        add(3, 39, 3'd3, LIGHT_RED, LIGHT_GRN);
        add(3, 40, 3'd6, LIGHT_YEL, LIGHT_RED);
        add(3, 42, 3'd6, LIGHT_YEL, LIGHT_RED);
        add(3, 43, 3'd6, LIGHT_OFF, LIGHT_OFF);
        add(3, 46, 3'd6, LIGHT_OFF, LIGHT_OFF);
        add(3, 47, 3'd6, LIGHT_YEL, LIGHT_RED);
        add(3, 51, 3'd6, LIGHT_OFF, LIGHT_OFF);
        add(3, 52, 3'd6, LIGHT_OFF, LIGHT_OFF);
        add(3, 53, 3'd5, LIGHT_RED, LIGHT_RED);
        add(3, 54, 3'd5, LIGHT_RED, LIGHT_RED);
        add(3, 55, 3'd0, LIGHT_GRN, LIGHT_RED);
        add(3, 74, 3'd0, LIGHT_GRN, LIGHT_RED);
        add(3, 75, 3'd1, LIGHT_YEL, LIGHT_RED);

        add(4, 19, 3'd1, LIGHT_YEL, LIGHT_RED);
        add(4, 30, 3'd1, LIGHT_YEL, LIGHT_RED);
        add(4, 31, 3'd3, LIGHT_RED, LIGHT_GRN);
        add(4, 46, 3'd3, LIGHT_RED, LIGHT_GRN);
        add(4, 47, 3'd4, LIGHT_RED, LIGHT_YEL);
        add(4, 58, 3'd4, LIGHT_RED, LIGHT_YEL);
        add(4, 59, 3'd0, LIGHT_GRN, LIGHT_RED);

        for (int t = 0; t < 5; t++) begin
            do_reset();
            for (int c = 0; c < ttab[t].ncyc; c++) begin
                sensor     = ((c >= ttab[t].s1_lo) && (c <= ttab[t].s1_hi)) ||
                             ((c >= ttab[t].s2_lo) && (c <= ttab[t].s2_hi));
                flash_mode = (c >= ttab[t].f_lo) && (c <= ttab[t].f_hi);
                foreach (etab[i])
                    if ((etab[i].tst == t) && (etab[i].cyc == c)) sb.push_back(etab[i]);
                step();
                while (sb.size() > 0) begin
                    e = sb.pop_front();
                    if (t == 4) chk("seq_ar0",  c, {st0, lh0, lf0}, {e.st, e.lh, e.lf});
                    else        chk("seq_main", c, {st, lh, lf},    {e.st, e.lh, e.lf});
                end
                if (t == 0) chk("tick_period", c, {8'd0, dut.w_tick}, {8'd0, ((c % 4) == 2)});
                if (t == 4) begin
                    n_cmp++;
                    if ((st0 == 3'd2) || (st0 == 3'd5)) begin
                        n_bad++;
                        $display("FAIL no_allred cyc=%0d actual=%0d required=not 2/5", c, st0);
                    end
                end
            end
        end

        // reset during HRED_FYEL with sensor high
        do_reset();
        for (int c = 0; c < 56; c++) begin
            sensor = (c == 2);
            step();
        end
        chk("pre_rst_state", 55, {6'd0, st}, {6'd0, 3'd4});
        rst = 1'b1; sensor = 1'b1;
        step();
        chk("rst_mid_lights", 56, {st, lh, lf}, {3'd0, LIGHT_GRN, LIGHT_RED});
        chk("rst_mid_req",    56, {8'd0, dut.r_req},  9'd0);
        chk("rst_mid_tick",   56, {8'd0, dut.w_tick}, 9'd0);
        rst = 1'b0;
        step();
        chk("relatch_req", 57, {8'd0, dut.r_req}, 9'd1);
        sensor = 1'b0;
        step();
        chk("restart_tick_lo", 58, {8'd0, dut.w_tick}, 9'd0);
        step();
        chk("restart_tick_hi", 59, {8'd0, dut.w_tick}, 9'd1);
        for (int c = 60; c < 76; c++) step();
        chk("post_rst_green", 75, {6'd0, st}, {6'd0, 3'd0});
        step();
        chk("post_rst_yel",   76, {6'd0, st}, {6'd0, 3'd1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
